// File: rtl/c1541_pkg.sv
// Shared constants and enumerations for the 1541 sector transfer scheduler.
package c1541_pkg;

   localparam int LBA_PER_TRACK = 16;
   localparam int SEC_W         = 4;
   localparam int HT_W          = 7;
   localparam int META_LBAS     = 2;

   localparam logic [HT_W-1:0] META_TRACK       = 7'd84;
   localparam logic [HT_W-1:0] RESET_HALF_TRACK = 7'd36;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_XFER,
      ST_NEXT
   } sched_state_t;

   typedef enum logic [1:0] {
      OP_WB,
      OP_LOAD,
      OP_META
   } sched_op_t;

endpackage

// File: rtl/c1541_ack_sync.sv
// Brings the host acknowledge into clk: two flops, and the output only follows
// once both stages agree, so a single-cycle glitch never reaches the FSM.
module c1541_ack_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_out
);

   logic s1_reg;
   logic s2_reg;
   logic out_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_reg  <= 1'b0;
         s2_reg  <= 1'b0;
         out_reg <= 1'b0;
      end else begin
         s1_reg <= async_in;
         s2_reg <= s1_reg;
         if (s1_reg == s2_reg)
            out_reg <= s2_reg;
      end
   end

   assign sync_out = out_reg;

endmodule

// File: rtl/c1541_lba_sched.sv
// Sequences dirty-sector writebacks, track loads and metadata loads onto the
// single host sector port, and owns the resident half-track and buffer window.
module c1541_lba_sched
   import c1541_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              dirty_set,
   input  logic [SEC_W-1:0]  dirty_lba,
   input  logic              load_req,
   input  logic [HT_W-1:0]   load_half_track,
   input  logic [SEC_W-1:0]  load_start_lba,
   input  logic              meta_req,
   input  logic              abort,
   input  logic              sd_ack,
   output logic              sd_rd,
   output logic              sd_wr,
   output logic [31:0]       sd_lba,
   output logic [SEC_W-1:0]  buff_base,
   output logic              meta_sel,
   output logic [HT_W-1:0]   cur_half_track,
   output logic              busy,
   output logic              load_done,
   output logic              wb_pending
);

   sched_state_t state_reg, state_next;
   sched_op_t    op_reg;

   logic [HT_W-1:0]          cur_half_track_reg;
   logic [SEC_W-1:0]         buff_base_reg;
   logic [SEC_W-1:0]         sec_cnt_reg;
   logic [LBA_PER_TRACK-1:0] dirty_reg;
   logic                     meta_pend_reg;
   logic                     load_done_reg;

   logic             ack;
   logic             dirty_any;
   logic [SEC_W-1:0] low_idx;
   logic             dirty_block;
   logic             take_meta, take_wb, take_load, step, finish_load;

   c1541_ack_sync u_ack_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (sd_ack),
      .sync_out (ack)
   );

   assign dirty_any = |dirty_reg;

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      low_idx = '0;
      for (int i = LBA_PER_TRACK - 1; i >= 0; i--) begin
         if (dirty_reg[i])
            low_idx = SEC_W'(i);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      take_meta   = 1'b0;
      take_wb     = 1'b0;
      take_load   = 1'b0;
      step        = 1'b0;
      finish_load = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (meta_pend_reg)
               take_meta = 1'b1;
            else if (dirty_any)
               take_wb = 1'b1;
            else if (load_req)
               take_load = 1'b1;
            if (take_meta || take_wb || take_load)
               state_next = ST_REQ;
         end
         ST_REQ: begin
            if (ack)
               state_next = ST_XFER;
         end
         ST_XFER: begin
            if (!ack)
               state_next = ST_NEXT;
         end
         ST_NEXT: begin
            state_next = ST_IDLE;
            if (meta_pend_reg) begin
               take_meta = 1'b1;
            end else begin
               case (op_reg)
                  OP_WB: begin
                     if (dirty_any)
                        take_wb = 1'b1;
                  end
                  OP_LOAD: begin
                     if (!abort) begin
                        if (sec_cnt_reg == SEC_W'(LBA_PER_TRACK - 1))
                           finish_load = 1'b1;
                        else
                           step = 1'b1;
                     end
                  end
                  OP_META: begin
                     if (sec_cnt_reg != SEC_W'(META_LBAS - 1))
                        step = 1'b1;
                  end
                  default: ;
               endcase
            end
            if (take_meta || take_wb || step)
               state_next = ST_REQ;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      sd_rd = 1'b0;
      sd_wr = 1'b0;
      busy  = (state_reg != ST_IDLE);
      if (state_reg == ST_REQ) begin
         if (op_reg == OP_WB)
            sd_wr = 1'b1;
         else
            sd_rd = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_reg             <= OP_LOAD;
         cur_half_track_reg <= RESET_HALF_TRACK;
         buff_base_reg      <= '0;
         sec_cnt_reg        <= '0;
         meta_pend_reg      <= 1'b0;
         load_done_reg      <= 1'b0;
      end else begin
         load_done_reg <= finish_load;
         meta_pend_reg <= meta_req | (meta_pend_reg & ~take_meta);
         if (take_meta) begin
            op_reg             <= OP_META;
            cur_half_track_reg <= META_TRACK;
            buff_base_reg      <= '0;
            sec_cnt_reg        <= '0;
         end else if (take_wb) begin
            op_reg        <= OP_WB;
            buff_base_reg <= low_idx;
         end else if (take_load) begin
            op_reg             <= OP_LOAD;
            cur_half_track_reg <= load_half_track;
            buff_base_reg      <= load_start_lba;
            sec_cnt_reg        <= '0;
         end else if (step) begin
            buff_base_reg <= buff_base_reg + 1'b1;
            sec_cnt_reg   <= sec_cnt_reg + 1'b1;
         end
      end
   end

   // Marks against the metadata image are meaningless, so they are dropped.
   assign dirty_block = meta_sel && ((state_reg == ST_IDLE) || (op_reg == OP_META));

   generate
      for (genvar gi = 0; gi < LBA_PER_TRACK; gi++) begin : g_dirty
         logic set_hit;
         logic clr_hit;
         assign set_hit = dirty_set && !dirty_block && (dirty_lba == SEC_W'(gi));
         assign clr_hit = take_wb && (low_idx == SEC_W'(gi));
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               dirty_reg[gi] <= 1'b0;
            else if (take_meta)
               dirty_reg[gi] <= 1'b0;
            else if (set_hit)
               dirty_reg[gi] <= 1'b1;
            else if (clr_hit)
               dirty_reg[gi] <= 1'b0;
         end
      end
   endgenerate

   assign cur_half_track = cur_half_track_reg;
   assign buff_base      = buff_base_reg;
   assign meta_sel       = (cur_half_track_reg == META_TRACK);
   assign sd_lba         = {21'b0, cur_half_track_reg, buff_base_reg};
   assign load_done      = load_done_reg;
   assign wb_pending     = dirty_any;

endmodule

// File: tb/tb_c1541_lba_sched.sv
// Self-checking bench for c1541_lba_sched: a randomly paced host logs every
// sector request, and the log is compared against sequences built from the rules.
module tb_c1541_lba_sched;
   import c1541_pkg::*;

   typedef struct packed {
      logic        wr;
      logic [31:0] lba;
   } trans_t;

   typedef struct {
      logic [6:0] track;
      logic [3:0] start;
      int         abort_at;
      int         exp_reads;
      int         exp_done;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        dirty_set = 1'b0;
   logic [3:0]  dirty_lba = '0;
   logic        load_req = 1'b0;
   logic [6:0]  load_half_track = '0;
   logic [3:0]  load_start_lba = '0;
   logic        meta_req = 1'b0;
   logic        abort = 1'b0;
   logic        sd_ack;
   logic        sd_rd, sd_wr;
   logic [31:0] sd_lba;
   logic [3:0]  buff_base;
   logic        meta_sel;
   logic [6:0]  cur_half_track;
   logic        busy, load_done, wb_pending;

   int     checks = 0;
   int     failures = 0;
   int     done_cnt = 0;
   bit     host_hold = 1'b0;
   trans_t log_q[$];
   trans_t exp_q[$];

   always #5 clk = ~clk;

   c1541_lba_sched dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .dirty_set       (dirty_set),
      .dirty_lba       (dirty_lba),
      .load_req        (load_req),
      .load_half_track (load_half_track),
      .load_start_lba  (load_start_lba),
      .meta_req        (meta_req),
      .abort           (abort),
      .sd_ack          (sd_ack),
      .sd_rd           (sd_rd),
      .sd_wr           (sd_wr),
      .sd_lba          (sd_lba),
      .buff_base       (buff_base),
      .meta_sel        (meta_sel),
      .cur_half_track  (cur_half_track),
      .busy            (busy),
      .load_done       (load_done),
      .wb_pending      (wb_pending)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Host side: log the request, ack after a random delay, release after a random delay.
   initial begin : host
      sd_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!host_hold && reset_n && (sd_rd || sd_wr)) begin
            int     k;
            trans_t t;
            t.wr  = sd_wr;
            t.lba = sd_lba;
            log_q.push_back(t);
            $display("txn %s half_track=%0d sector=%0d", sd_wr ? "wr" : "rd", sd_lba[10:4], sd_lba[3:0]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sd_ack = 1'b1;
            k = 0;
            do begin
               @(negedge clk);
               k++;
            end while ((sd_rd || sd_wr) && k < 50);
            chk("req_drop_latency", 32'(k), 32'd4);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sd_ack = 1'b0;
            for (int j = 0; j < 4; j++) begin
               @(negedge clk);
               chk("req_gap_after_ack_fall", 32'(sd_rd | sd_wr), 32'd0);
            end
         end
      end
   end

   initial begin : done_mon
      logic prev_busy;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (load_done) begin
            done_cnt++;
            chk("load_done_with_busy_fall", 32'({busy, prev_busy}), 32'b01);
         end
         prev_busy = busy;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_load(input logic [6:0] t, input logic [3:0] s, input int n);
      for (int i = 0; i < n; i++) begin
         trans_t   e;
         logic [3:0] sec;
         sec   = s + 4'(i);
         e.wr  = 1'b0;
         e.lba = {21'b0, t, sec};
         exp_q.push_back(e);
      end
   endtask

   task automatic model_wb(input logic [6:0] t, input logic [15:0] mask);
      for (int i = 0; i < 16; i++) begin
         if (mask[i]) begin
            trans_t e;
            e.wr  = 1'b1;
            e.lba = {21'b0, t, 4'(i)};
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic check_log(input string name);
      chk({name, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL %s[%0d]: got wr=%0b lba=%0h want wr=%0b lba=%0h",
                     name, i, log_q[i].wr, log_q[i].lba, exp_q[i].wr, exp_q[i].lba);
         end
      end
   endtask

   task automatic clear_logs();
      log_q.delete();
      exp_q.delete();
   endtask

   task automatic wait_quiet(input int abort_at, input string name);
      int quiet;
      int n;
      quiet = 0;
      n = 0;
      while (quiet < 8 && n < 3000) begin
         @(negedge clk);
         n++;
         if (sd_rd) load_req = 1'b0;
         if (abort_at != 0 && busy && log_q.size() >= abort_at) abort = 1'b1;
         if (!busy) abort = 1'b0;
         quiet = (!busy && !wb_pending && !sd_ack) ? quiet + 1 : 0;
      end
      chk({name, "_settle"}, 32'(quiet >= 8), 32'd1);
   endtask

   task automatic start_load(input logic [6:0] t, input logic [3:0] s);
      @(negedge clk);
      chk("idle_before_accept", 32'({sd_rd, busy}), 32'd0);
      load_half_track = t;
      load_start_lba  = s;
      load_req        = 1'b1;
      @(negedge clk);
      chk("accept_rd_busy", 32'({sd_rd, busy}), 32'b11);
      chk("accept_lba", sd_lba, {21'b0, t, s});
      load_req = 1'b0;
   endtask

   initial begin : main
      vec_t vecs[6];
      int   d0;

      vecs[0] = '{7'd38, 4'd5,  0,  16, 1};
      vecs[1] = '{7'd37, 4'd0,  4,  4,  0};
      vecs[2] = '{7'd83, 4'd15, 0,  16, 1};
      vecs[3] = '{7'd0,  4'd9,  1,  1,  0};
      vecs[4] = '{7'd12, 4'd3,  16, 16, 0};
      vecs[5] = '{7'd36, 4'd0,  0,  16, 1};

      repeat (3) @(negedge clk);
      chk("rst_rd_wr", 32'({sd_rd, sd_wr}), 32'd0);
      chk("rst_busy_done_wb", 32'({busy, load_done, wb_pending}), 32'd0);
      chk("rst_track", 32'(cur_half_track), 32'd36);
      chk("rst_bb_meta", 32'({buff_base, meta_sel}), 32'd0);
      chk("rst_lba", sd_lba, {21'b0, 7'd36, 4'd0});
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", 32'({busy, sd_rd, sd_wr, wb_pending}), 32'd0);

      // Table-driven loads, with and without abort.
      for (int r = 0; r < 6; r++) begin
         clear_logs();
         d0 = done_cnt;
         start_load(vecs[r].track, vecs[r].start);
         wait_quiet(vecs[r].abort_at, "load");
         model_load(vecs[r].track, vecs[r].start, vecs[r].exp_reads);
         check_log($sformatf("load_vec%0d", r));
         chk("load_done_count", 32'(done_cnt - d0), 32'(vecs[r].exp_done));
         chk("load_track", 32'(cur_half_track), 32'(vecs[r].track));
         chk("load_final_bb", 32'(buff_base), 32'((vecs[r].start + vecs[r].exp_reads - 1) % 16));
      end

      // Dirty 3 and 9 on track 36, then a load of 37.
      clear_logs();
      d0 = done_cnt;
      @(negedge clk);
      dirty_set = 1'b1; dirty_lba = 4'd3;
      @(negedge clk);
      dirty_lba = 4'd9;
      @(negedge clk);
      dirty_set = 1'b0;
      load_half_track = 7'd37; load_start_lba = 4'd0; load_req = 1'b1;
      wait_quiet(0, "wb_then_load");
      model_wb(7'd36, 16'h0208);
      model_load(7'd37, 4'd0, 16);
      check_log("wb_then_load");
      chk("wb_then_load_done", 32'(done_cnt - d0), 32'd1);

      // Metadata request during a writeback.
      clear_logs();
      d0 = done_cnt;
      @(negedge clk);
      dirty_set = 1'b1; dirty_lba = 4'd2;
      @(negedge clk);
      dirty_lba = 4'd5;
      @(negedge clk);
      chk("wb_accept_wr", 32'(sd_wr), 32'd1);
      dirty_lba = 4'd11;
      @(negedge clk);
      dirty_set = 1'b0; meta_req = 1'b1;
      @(negedge clk);
      meta_req = 1'b0;
      for (int n = 0; n < 300 && cur_half_track != 7'd84; n++) @(negedge clk);
      chk("meta_track_reached", 32'(cur_half_track), 32'd84);
      dirty_set = 1'b1; dirty_lba = 4'd7;
      @(negedge clk);
      dirty_set = 1'b0;
      wait_quiet(0, "meta");
      exp_q.push_back('{1'b1, {21'b0, 7'd37, 4'd2}});
      model_load(7'd84, 4'd0, 2);
      check_log("meta");
      chk("meta_wb_pending", 32'(wb_pending), 32'd0);
      chk("meta_sel_high", 32'(meta_sel), 32'd1);
      chk("meta_bb", 32'(buff_base), 32'd1);
      chk("meta_no_done", 32'(done_cnt - d0), 32'd0);

      @(negedge clk);
      dirty_set = 1'b1; dirty_lba = 4'd4;
      @(negedge clk);
      dirty_set = 1'b0;
      repeat (3) @(negedge clk);
      chk("meta_idle_dirty_ignored", 32'({wb_pending, busy}), 32'd0);

      // Re-dirty one cycle after the writeback entered REQ.
      start_load(7'd36, 4'd0);
      wait_quiet(0, "reload36");
      clear_logs();
      @(negedge clk);
      dirty_set = 1'b1; dirty_lba = 4'd3;
      @(negedge clk);
      dirty_set = 1'b0;
      @(negedge clk);
      chk("redirty_wr_active", 32'(sd_wr), 32'd1);
      dirty_set = 1'b1;
      @(negedge clk);
      dirty_set = 1'b0;
      chk("redirty_pending", 32'(wb_pending), 32'd1);
      wait_quiet(0, "redirty");
      model_wb(7'd36, 16'h0008);
      model_wb(7'd36, 16'h0008);
      check_log("redirty");

      // Set and clear of the same bit in the same cycle: set wins.
      clear_logs();
      @(negedge clk);
      dirty_set = 1'b1; dirty_lba = 4'd6;
      @(negedge clk);
      @(negedge clk);
      dirty_set = 1'b0;
      wait_quiet(0, "set_wins");
      model_wb(7'd36, 16'h0040);
      model_wb(7'd36, 16'h0040);
      check_log("set_wins");

      // Random loads with dirty marks arriving mid-load.
      for (int it = 0; it < 6; it++) begin
         logic [6:0]  t;
         logic [3:0]  s;
         logic [15:0] mask;
         int          nd;
         t    = 7'($urandom_range(0, 83));
         s    = 4'($urandom_range(0, 15));
         mask = '0;
         nd   = $urandom_range(0, 5);
         clear_logs();
         d0 = done_cnt;
         start_load(t, s);
         for (int j = 0; j < nd; j++) begin
            logic [3:0] idx;
            idx = 4'($urandom_range(0, 15));
            dirty_set = 1'b1;
            dirty_lba = idx;
            mask[idx] = 1'b1;
            @(negedge clk);
         end
         dirty_set = 1'b0;
         wait_quiet(0, "rand");
         model_load(t, s, 16);
         model_wb(t, mask);
         check_log($sformatf("rand%0d", it));
         chk("rand_done", 32'(done_cnt - d0), 32'd1);
         chk("rand_track", 32'(cur_half_track), 32'(t));
      end

      // Reset in the middle of a request.
      host_hold = 1'b1;
      start_load(7'd50, 4'd2);
      repeat (2) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_rd", 32'(sd_rd), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_track", 32'(cur_half_track), 32'd36);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      host_hold = 1'b0;
      @(negedge clk);
      chk("post_rst_track", 32'(cur_half_track), 32'd36);
      chk("post_rst_lba", sd_lba, {21'b0, 7'd36, 4'd0});
      chk("post_rst_flags", 32'({sd_rd, sd_wr, busy, load_done, wb_pending}), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/c1541_lba_sched.md
# c1541_lba_sched

Sector transfer scheduler for the 1541 GCR track buffer. Takes dirty-sector writebacks, track loads and metadata loads, and sequences them onto the single host sector port (`sd_lba`/`sd_rd`/`sd_wr`/`sd_ack`). Writebacks of the resident track are serialized ahead of any load. It drives the buffer window select (`buff_base`, `meta_sel`) and owns `cur_half_track`, which sits between the head/bit-clock logic and the track buffer RAM.

## Interface
- `LBA_PER_TRACK`, 16, sectors per half-track image; fixes 4-bit sector index.
- `META_TRACK`, 84, half-track number holding the metadata table.
- `META_LBAS`, 2, sectors in the metadata table.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `dirty_set` in 1: pulse; marks sector `dirty_lba` of the resident track dirty.
- `dirty_lba` in 4: sector index for `dirty_set`.
- `load_req` in 1: level; request the load of `load_half_track`.
- `load_half_track` in 7: target half-track, 0..83.
- `load_start_lba` in 4: first sector to fetch.
- `meta_req` in 1: pulse on disk change; load the metadata table.
- `abort` in 1: level; stop the in-progress load at the next sector boundary.
- `sd_ack` in 1: host acknowledge, from another clock domain.
- `sd_rd`, `sd_wr` out 1: sector read/write request.
- `sd_lba` out 32: `{21'b0, cur_half_track, buff_base}`.
- `buff_base` out 4: sector window of the track buffer.
- `meta_sel` out 1: high while `cur_half_track == META_TRACK`.
- `cur_half_track` out 7: resident track.
- `busy` out 1: a sequence is active.
- `load_done` out 1: one-cycle pulse when a full load completes.
- `wb_pending` out 1: the dirty bitmap is non-zero.

## Operation
- The ack synchronizer is two flops plus a stability filter. `ack` updates only when both sync stages agree, giving 3 cycles of latency.
- FSM states:
  - **IDLE**: priority is meta_req latch > writeback (dirty≠0 and (`load_req` with `load_half_track≠cur_half_track`, or any dirty)) > load.
  - **REQ**: holds `sd_rd` or `sd_wr` high until `ack` is seen high, then clears it and goes to XFER.
  - **XFER**: waits for `ack` to fall, then goes to NEXT.
  - **NEXT**: one decision cycle, then REQ or IDLE.
- Writeback:
  - Picks the lowest set dirty bit and sets `buff_base` to it.
  - Clears that bit on entry to REQ.
  - A `dirty_set` on the same index after that cycle re-sets it.
  - After each sector, NEXT rechecks the bitmap. The load starts only when the bitmap is empty.
- Load:
  - Latches `load_half_track` into `cur_half_track` and `load_start_lba` into `buff_base`.
  - Issues 16 reads with `buff_base` incrementing mod 16.
  - After the 16th: pulses `load_done`, goes to IDLE.
- Meta:
  - Sets `cur_half_track=META_TRACK` and `buff_base=0`, then reads `META_LBAS` sectors.
  - Clears the dirty bitmap on acceptance, discarding the old disk.
  - Then goes to IDLE. No `load_done` pulse.
- `meta_req` is latched and takes effect at the next IDLE or NEXT.
- Abort: in NEXT during a load, `abort=1` ends the sequence: IDLE, no `load_done`. `abort` is ignored during writeback and meta.
- `dirty_set` while in IDLE/meta with `meta_sel=1` is ignored.

## Timing
- Reset values:
  - `sd_rd=sd_wr=0`, `busy=0`, `load_done=0`, `wb_pending=0`.
  - `buff_base=0`, `cur_half_track=36`, `meta_sel=0`.
  - Bitmap and meta latch cleared; state IDLE.
- Acceptance to request: `sd_rd`/`sd_wr` rise 1 cycle after the accepting IDLE cycle. `busy` rises the same cycle.
- Request drop: `sd_rd`/`sd_wr` fall the cycle after `ack` is seen high.
- Sector to sector: the next request rises 2 cycles after `ack` falls (XFER→NEXT→REQ).
- Completion: `busy` falls the cycle after NEXT. `load_done` is asserted in that same cycle.
- `dirty_set` and bit clear in the same cycle for the same index: set wins.
- Reset mid-transfer: outputs clear immediately (async). The host must tolerate a request dropping without ack.

## Structure
- Shared package `c1541_pkg`:
  - `LBA_PER_TRACK`, `META_TRACK`, `META_LBAS`, reset half-track 36.
  - FSM state enum `sched_state_t` and op enum `{OP_WB, OP_LOAD, OP_META}`.
- One sub-module: `c1541_ack_sync` (two-flop sync plus agreement filter).
- Priority encoder for the lowest dirty bit is inline.

## Test plan
- Load from idle, track 36→38, start 5 → `sd_lba` low nibbles 5,6..15,0..4 with `{cur_half_track=38}`; one `load_done` after the 16th ack fall.
- Dirty 3 and 9 on track 36, then `load_req` to 37 → `sd_wr` at lba {36,3}, then {36,9}, then 16 reads on 37.
- `meta_req` during a writeback → current sector finishes; next reads are {84,0},{84,1}; bitmap cleared; `wb_pending=0`.
- `abort` asserted during the 4th load sector → exactly 4 reads, `busy` low, no `load_done`.
- `dirty_set` for sector 3 one cycle after its writeback entered REQ → a second write of {36,3} follows.
- `reset_n` low mid-XFER → `sd_rd=0` and `busy=0` asynchronously; `cur_half_track=36` after release.
